// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back queue: buffers write requests in a FIFO and issues
// them to the register file write port, with a hazard query over queued entries.
module regfile_wb_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]       addr_q  [DEPTH];
  logic [4:0]       addr_d  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic push, pop, hit;

  // rst gates in_ready so no handshake can complete while reset is held
  assign in_ready = rst & (count_q < FULL);
  assign rf_we    = (count_q != '0) & ~rf_stall;
  assign rf_waddr = (count_q != '0) ? addr_q[head_q] : '0;
  assign rf_wdata = (count_q != '0) ? data_q[head_q] : '0;
  assign count    = count_q;
  assign idle     = (count_q == '0);

  assign push = in_valid & in_ready & (in_addr != '0);
  assign pop  = rf_we;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit = hit | (valid_q[i] & (addr_q[i] == q_addr));
    end
  end

  assign q_pending = (q_addr != '0) & hit;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // push never lands on the head slot while it is still occupied: a push
    // requires count<DEPTH, so tail==head implies the queue is empty
    if (push) begin
      addr_d[tail_q]  = in_addr;
      data_d[tail_q]  = in_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + AW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of write-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port in_valid, input, 1 bit: the producer offers a write request.
REQ-005 SHALL have port in_addr, input, 5 bits: the destination register number.
REQ-006 SHALL have port in_data, input, 32 bits: the value to write.
REQ-007 SHALL have port in_ready, output, 1 bit: the queue can accept a request this cycle.
REQ-008 SHALL have port rf_stall, input, 1 bit: inhibits issue to the register file while high.
REQ-009 SHALL have port rf_we, output, 1 bit: write enable to the register file write port.
REQ-010 SHALL have port rf_waddr, output, 5 bits: register file write address.
REQ-011 SHALL have port rf_wdata, output, 32 bits: register file write data.
REQ-012 SHALL have port q_addr, input, 5 bits: hazard-query register number.
REQ-013 SHALL have port q_pending, output, 1 bit: a queued write targets q_addr.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of queued entries.
REQ-015 SHALL have port idle, output, 1 bit: the queue is empty.

Function
REQ-016 SHALL accept a request at a rising edge where in_valid=1 and in_ready=1 (handshake).
REQ-017 SHALL drive in_ready = (count < DEPTH); in_ready SHALL NOT depend on a same-cycle pop.
REQ-018 SHALL discard an accepted request with in_addr=0 (handshake completes, nothing enqueued, count unchanged).
REQ-019 SHALL append an accepted request with in_addr!=0 at the FIFO tail in acceptance order.
REQ-020 SHALL drive rf_we = (count!=0) & ~rf_stall combinationally from registered state, and rf_waddr/rf_wdata from the head entry.
REQ-021 SHALL pop the head at each rising edge where rf_we=1.
REQ-022 SHALL hold rf_waddr=0 and rf_wdata=0 while count=0.
REQ-023 SHALL give a latency of one cycle: a request accepted at edge n produces rf_we=1 during the cycle after edge n (empty queue, rf_stall=0) and is written at edge n+1.
REQ-024 SHALL NOT bypass: an empty queue never issues a request in the same cycle it is offered.
REQ-025 SHALL support simultaneous push and pop in one edge with count unchanged, including at count=DEPTH-1.
REQ-026 SHALL wrap the head and tail pointers modulo DEPTH without loss or duplication.
REQ-027 SHALL drive q_pending=1 iff q_addr!=0 and any valid entry (including the head) has a matching address; combinational.
REQ-028 SHALL drive idle = (count==0).
REQ-029 SHALL leave state unchanged while rf_stall=1 and in_valid=0; a stalled head stays presented unchanged.

Reset
REQ-030 SHALL, on rst=0, immediately clear count, the pointers and all entry-valid state regardless of clk.
REQ-031 SHALL, during reset, drive rf_we=0, rf_waddr=0, rf_wdata=0, q_pending=0, count=0, idle=1 and in_ready=0.
REQ-032 SHALL drop any entries queued before a mid-operation reset; none of them is issued after rst returns to 1.
REQ-033 SHALL drive in_ready=1 from the first cycle after rst deasserts.

Verification
REQ-034 Single write: empty queue, accept (addr 5, 0xDEADBEEF) at edge 1 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1-2; idle=1 after edge 2.
REQ-035 Fill and stall: rf_stall=1, offer 5 requests to addrs 1..5 with DEPTH=4 -> 4 accepted, in_ready=0, count=4; release rf_stall -> writes issue in order 1,2,3,4 on consecutive edges; addr 5 is accepted afterwards.
REQ-036 Register zero: accept (addr 0, 0x12345678) -> count stays 0, rf_we never asserted; q_addr=0 -> q_pending=0.
REQ-037 Hazard query: queue addrs 7 and 9 under stall -> q_addr=9 gives q_pending=1, q_addr=8 gives 0; after both pops q_addr=9 gives 0.
REQ-038 Push and pop with wrap: stream 20 back-to-back requests with rf_stall=0 -> count <= 1 throughout, 20 writes issued in order with matching data.
REQ-039 Mid-operation reset: 3 queued, pulse rst=0 between edges -> rf_we=0 and count=0 immediately; no stale write after release.
